// File: rtl/dna_pkg.sv
// Shared definitions for the differential frame encoder.
//   digit_t   : one 2-bit symbol
//   state_t   : frame controller FSM states
//   DNA_N_DEF : default number of digits per word
package dna_pkg;

  typedef logic [1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DNA_N_DEF = 8;

endpackage

// File: rtl/diff_chain_core.sv
// Combinational mod-4 differential encoder for one word.
//   word       : N 2-bit digits, MS digit first in sequence
//   prev_digit : digit preceding the MS digit (seed or previous word's LS digit)
//   enc        : enc digit i = word digit i minus the digit before it, wrapping mod 4
module diff_chain_core
  import dna_pkg::*;
#(
  parameter int N = DNA_N_DEF
) (
  input  logic [2*N-1:0] word,
  input  digit_t         prev_digit,
  output logic [2*N-1:0] enc
);

  // The MS digit differences against the digit carried in from outside the word.
  assign enc[2*N-1 -: 2] = word[2*N-1 -: 2] - prev_digit;

  for (genvar i = 0; i < N - 1; i++) begin : g_diff
    assign enc[2*i +: 2] = word[2*i +: 2] - word[2*i+2 +: 2];
  end

endmodule

// File: rtl/diff_frame_ctrl.sv
// Frame controller around the differential encoder.
//   cfg_start/cfg_len/cfg_seed : start a frame of cfg_len words, seeded with cfg_seed
//   cfg_abort                  : drop the current frame, back to IDLE
//   in_valid/in_ready/in_word  : input word stream
//   out_valid/out_ready/out_word/out_last : encoded stream, one output register
//   busy     : not IDLE
//   done     : pulse after the last word is taken downstream
//   err_len0 : pulse when a start is rejected for cfg_len==0
module diff_frame_ctrl
  import dna_pkg::*;
#(
  parameter int N     = DNA_N_DEF,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [1:0]       cfg_seed,
  input  logic             cfg_abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_word,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err_len0
);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  digit_t           prev;
  logic [2*N-1:0]   enc;
  logic             accept;
  logic             out_hs;
  logic             last_word;

  diff_chain_core #(.N(N)) u_core (
    .word      (in_word),
    .prev_digit(prev),
    .enc       (enc)
  );

  // Output register may refill in the same cycle it is drained, so no bubbles.
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_word = (cnt == len - 1'b1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      prev      <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err_len0  <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_len0 <= 1'b0;
      if (cfg_abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              if (cfg_len != '0) begin
                len   <= cfg_len;
                prev  <= cfg_seed;
                cnt   <= '0;
                state <= RUN;
              end else begin
                err_len0 <= 1'b1;
              end
            end
          end
          RUN: begin
            if (accept) begin
              out_word  <= enc;
              out_valid <= 1'b1;
              out_last  <= last_word;
              prev      <= in_word[1:0];
              cnt       <= cnt + 1'b1;
              if (last_word) state <= DRAIN;
            end else if (out_hs) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
          DRAIN: begin
            // The output register holds the last word until it is taken.
            if (out_hs) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= out_last;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/diff_frame_ctrl.md
DIFF_FRAME_CTRL -- requirements
Module: diff_frame_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning digits per word (2 bits per digit).
REQ-002 SHALL have parameter LEN_W, default 8, meaning width of the frame-length field.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_start  input  1  single-cycle frame start request.
REQ-006 SHALL have port cfg_len  input  LEN_W  words per frame.
REQ-007 SHALL have port cfg_seed  input  2  previous-digit seed for the first word of a frame.
REQ-008 SHALL have port cfg_abort  input  1  synchronous frame abort.
REQ-009 SHALL have port in_valid  input  1  input word valid.
REQ-010 SHALL have port in_ready  output  1  input word accepted when in_valid&&in_ready.
REQ-011 SHALL have port in_word  input  2N  digits; the MS digit is first in sequence.
REQ-012 SHALL have port out_valid  output  1  encoded word valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts when out_valid&&out_ready.
REQ-014 SHALL have port out_word  output  2N  differentially encoded word.
REQ-015 SHALL have port out_last  output  1  qualifies the final word of a frame.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the last word is taken downstream.
REQ-018 SHALL have port err_len0  output  1  one-cycle pulse when cfg_start is rejected because cfg_len==0.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-020 IDLE SHALL behave as follows: in_ready=0; on cfg_start with cfg_len!=0, latch len, set prev=cfg_seed, set cnt=0, and go to RUN.
REQ-021 IDLE SHALL, on cfg_start with cfg_len==0, pulse err_len0 on the next cycle and remain in IDLE.
REQ-022 cfg_start SHALL be ignored in RUN and DRAIN, and the latched len and seed SHALL be unaffected.
REQ-023 RUN SHALL drive in_ready = !out_valid || out_ready, giving a single output register with no bubbles under continuous flow.
REQ-024 On accept, the encoder SHALL compute digit N-1 = (in MS digit - prev) mod 4 and digit i = (in[i] - in[i+1]) mod 4 for i=N-2..0, with 2-bit wrap-around subtraction.
REQ-025 On accept, prev SHALL be set to the input's LS digit (in_word[1:0]), chaining the difference across words.
REQ-026 Latency SHALL be 1 cycle: out_valid rises the cycle after acceptance.
REQ-027 On accept, cnt SHALL increment; the accept with cnt==len-1 SHALL set out_last with that word and move the FSM to DRAIN.
REQ-028 DRAIN SHALL hold in_ready=0; on the out handshake with out_last, done SHALL pulse next cycle, out_valid and out_last SHALL clear, and the FSM SHALL return to IDLE.
REQ-029 While out_valid=1 and out_ready=0, out_word and out_last SHALL hold stable.
REQ-030 When out handshake and in accept occur in the same cycle, the output register SHALL load the new word and out_valid SHALL stay 1.
REQ-031 cfg_abort, in any state, SHALL return the FSM to IDLE next cycle, clear out_valid and out_last, generate no done pulse, and take priority over a simultaneous cfg_start.
REQ-032 len=1 SHALL pass directly from RUN to DRAIN on the first accept.
REQ-033 len=2^LEN_W-1 SHALL count without overflow.

Reset
REQ-034 On rst_n=0 the block SHALL asynchronously enter IDLE.
REQ-035 On rst_n=0, out_valid, out_last, out_word, in_ready, busy, done, err_len0, cnt, len and prev SHALL all be 0.
REQ-036 Reset asserted mid-frame SHALL discard the frame and produce no done pulse.
REQ-037 On release of rst_n, the first state change SHALL occur at the next rising clk edge.

Structure
REQ-038 A shared package dna_pkg SHALL hold the digit typedef (2-bit), the FSM state enum and the default N.
REQ-039 The mod-4 word differencing SHALL be a combinational sub-module diff_chain_core with inputs word and prev_digit and output encoded word.
REQ-040 diff_frame_ctrl SHALL hold all sequential state.

Verification
REQ-041 Bench SHALL cover: N=8, seed=0, len=2, words 16'h1B1B then 16'h0000 -> out 16'h1555 then 16'h4000, out_last on second word, done pulse one cycle after its handshake.
REQ-042 Bench SHALL cover: cfg_len=0 with cfg_start -> err_len0 pulses once, busy stays 0, in_ready stays 0.
REQ-043 Bench SHALL cover: len=4, out_ready held 0 for 3 cycles after the first output -> out_word stable, in_ready=0, no word lost or duplicated, 4 outputs in order.
REQ-044 Bench SHALL cover: len=8, in_valid and out_ready held 1 -> one word per cycle, out_valid continuous for 8 cycles, out_last only on the 8th.
REQ-045 Bench SHALL cover: cfg_abort after 2 of 5 words -> IDLE next cycle, out_valid=0, no done; a new frame with seed=3 and word 16'hFFFF -> 16'h0000.
REQ-046 Bench SHALL cover: rst_n pulsed low mid-frame -> all outputs 0 immediately, busy=0, no done.
